// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if -- pipeline <-> hazard controller signal bundle.
//
// master modport : pipeline side; drives the hazard inputs, receives the
//                  stall/flush/freeze controls and the multi-cycle start.
// slave modport  : hazard_ctrl side.
//
// Signals:
//   rs1D, rs2D  source registers of the instruction in D
//   rdE         destination register of the instruction in E
//   MemtoRegE   instruction in E is a load
//   MCycleOpE   instruction in E needs the multi-cycle unit
//   MCycleDone  multi-cycle result valid (1-cycle pulse)
//   PCSrcM      control transfer resolved taken in M
//   MemReqM     load/store active in M
//   MemReadyM   data memory completes its access this cycle
//   MCycleStart 1-cycle start pulse to the multi-cycle unit
//   Busy        freeze of the E->M and M->W registers
//   StallF/D    hold PC / F->D register
//   FlushD/E/M  clear F->D / D->E / E->M register
interface hazard_ctrl_if;
    logic [4:0] rs1D;
    logic [4:0] rs2D;
    logic [4:0] rdE;
    logic       MemtoRegE;
    logic       MCycleOpE;
    logic       MCycleDone;
    logic       PCSrcM;
    logic       MemReqM;
    logic       MemReadyM;
    logic       MCycleStart;
    logic       Busy;
    logic       StallF;
    logic       StallD;
    logic       FlushD;
    logic       FlushE;
    logic       FlushM;

    modport master (
        output rs1D, rs2D, rdE, MemtoRegE, MCycleOpE, MCycleDone,
               PCSrcM, MemReqM, MemReadyM,
        input  MCycleStart, Busy, StallF, StallD, FlushD, FlushE, FlushM
    );

    modport slave (
        input  rs1D, rs2D, rdE, MemtoRegE, MCycleOpE, MCycleDone,
               PCSrcM, MemReqM, MemReadyM,
        output MCycleStart, Busy, StallF, StallD, FlushD, FlushE, FlushM
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- central stall/flush sequencer for the 5-stage core.
//
// Detects load-use hazards, resolves taken redirects from M, sequences the
// multi-cycle unit through a start/done handshake and freezes the back end
// while data memory is not ready.  All stall/flush outputs are combinational
// from the inputs and the FSM state; only the state and the optional
// performance counters are registered.
//
// Ports:
//   CLK         clock, rising edge
//   RESET       synchronous, active-high reset
//   hz          hazard_ctrl_if.slave bundle (hazard inputs, control outputs)
//   StallCount  cycles with Busy or a load-use stall
//   FlushCount  cycles with a taken-redirect flush
//
// Build option: define HAZARD_PERF_EN to include the performance counters;
// without it StallCount and FlushCount are tied to zero.
module hazard_ctrl #(
    parameter int PERF_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    hazard_ctrl_if.slave          hz,
    output logic [PERF_WIDTH-1:0] StallCount,
    output logic [PERF_WIDTH-1:0] FlushCount
);

    typedef enum logic {
        IDLE    = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic mem_busy;
    logic load_use;
    logic mc_start;
    logic mc_busy;
    logic busy;
    logic redirect;
    logic lu_stall;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;

        mem_busy = hz.MemReqM & ~hz.MemReadyM;
        load_use = hz.MemtoRegE & (hz.rdE != 5'd0) &
                   ((hz.rdE == hz.rs1D) | (hz.rdE == hz.rs2D));

        // The older access in M wins: a start is held off while memory is
        // stalling, and a taken redirect squashes the op in E outright.
        mc_start = (state == IDLE) & hz.MCycleOpE & ~hz.PCSrcM & ~mem_busy;
        mc_busy  = ((state == MC_WAIT) & ~hz.MCycleDone) | mc_start;
        busy     = mc_busy | mem_busy;

        // While frozen the D/E inputs stay put, so redirects and load-use
        // bubbles are simply re-evaluated once Busy drops.
        redirect = ~busy & hz.PCSrcM;
        lu_stall = ~busy & ~hz.PCSrcM & load_use;

        unique case (state)
            IDLE: begin
                if (mc_start) begin
                    state_next = MC_WAIT;
                end
            end
            MC_WAIT: begin
                if (hz.MCycleDone) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        hz.MCycleStart = mc_start;
        hz.Busy        = busy;
        hz.StallF      = busy | lu_stall;
        hz.StallD      = busy | lu_stall;
        hz.FlushD      = redirect;
        hz.FlushE      = redirect | lu_stall;
        hz.FlushM      = redirect;
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (busy | lu_stall) begin
                StallCount <= StallCount + PERF_WIDTH'(1);
            end
            if (redirect) begin
                FlushCount <= FlushCount + PERF_WIDTH'(1);
            end
        end
    end
`else
    assign StallCount = '0;
    assign FlushCount = '0;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage core. Drives StallF/StallD, the shared Busy freeze for the E→M and M→W registers, and FlushD/FlushE/FlushM.
- Detects load-use hazards.
- Resolves taken branches/jumps signalled from M.
- Sequences the multi-cycle multiply/divide unit through a start/done handshake.
- Extends the freeze while data memory is not ready.

Parameters:
PERF_WIDTH, 32, width of optional performance counters

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  synchronous, active-high reset
rs1D  in  5  source reg 1 of instruction in D
rs2D  in  5  source reg 2 of instruction in D
rdE  in  5  destination reg of instruction in E
MemtoRegE  in  1  instruction in E is a load
MCycleOpE  in  1  instruction in E needs multi-cycle unit
MCycleDone  in  1  multi-cycle unit result valid (1-cycle pulse)
PCSrcM  in  1  control transfer resolved taken in M
MemReqM  in  1  load/store active in M
MemReadyM  in  1  data memory completes access this cycle
MCycleStart  out  1  1-cycle start pulse to multi-cycle unit
Busy  out  1  freeze E→M and M→W registers
StallF  out  1  hold PC
StallD  out  1  hold F→D register
FlushD  out  1  clear F→D register
FlushE  out  1  clear D→E register
FlushM  out  1  clear E→M register
StallCount  out  PERF_WIDTH  cycles with Busy or load-use stall (feature-gated)
FlushCount  out  PERF_WIDTH  taken redirects (feature-gated)

Behaviour:
- FSM states: IDLE, MC_WAIT. Reset → IDLE.
- Reset values: all outputs 0, counters 0.
- IDLE, MCycleOpE=1, PCSrcM=0, mem_busy=0:
  - assert MCycleStart for exactly one cycle.
  - go to MC_WAIT.
  - Busy=1 combinationally in that same cycle.
- MC_WAIT: Busy=1 and MCycleStart=0.
  - MCycleDone=1 → Busy=0 in that cycle; the pipeline advances; next state IDLE.
  - The advance loads a new E instruction, so there is no re-start of the same op.
- Definitions:
  - mem_busy = MemReqM & ~MemReadyM
  - mc_busy = (state==MC_WAIT & ~MCycleDone) | MCycleStart
  - Busy = mc_busy | mem_busy
- mem_busy in IDLE with MCycleOpE=1: MCycleStart is deferred until mem_busy=0 (M is older and has priority).
- Busy=1 forces StallF=StallD=1 and FlushD=FlushE=FlushM=0. Flushes and load-use bubbles are deferred; the frozen inputs persist until Busy drops.
- Load-use, evaluated only when Busy=0:
  - Condition: MemtoRegE & rdE≠0 & (rdE==rs1D | rdE==rs2D).
  - Response: StallF=StallD=1, FlushE=1 for one cycle.
- Taken redirect, evaluated only when Busy=0: PCSrcM=1 → FlushD=FlushE=FlushM=1. This overrides load-use (StallF=StallD=0) and suppresses MCycleStart for a flushed MCycleOpE.
- MCycleDone in IDLE is ignored.
- All flush/stall outputs are combinational from inputs and state. Only state and counters are registered.
- RESET mid-MC_WAIT → IDLE next edge; Busy=0 from then; no start pulse.

Optional Feature:
HAZARD_PERF_EN:
- Defined:
  - StallCount increments each cycle Busy=1 or a load-use stall is asserted.
  - FlushCount increments each cycle a taken redirect flush is asserted.
  - Both wrap modulo 2^PERF_WIDTH and clear on RESET.
- Undefined: no counter registers; StallCount and FlushCount are tied to 0.

Test Plan:
1. Load-use: MemtoRegE=1, rdE=5, rs2D=5 → one cycle of StallF=StallD=FlushE=1, Busy=0; with rdE=0 → no stall.
2. Multi-cycle: MCycleOpE=1 at cycle 0, MCycleDone at cycle 6 → MCycleStart only at cycle 0, Busy=1 cycles 0–5, Busy=0 cycle 6, state IDLE cycle 7.
3. Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles → Busy=StallF=StallD=1 for 3 cycles; MemReadyM=1 → all deasserted.
4. Branch vs load-use: PCSrcM=1 together with load-use match → FlushD=FlushE=FlushM=1, StallF=StallD=0.
5. Deferral: PCSrcM=1 while MemReqM=1, MemReadyM=0 for 2 cycles → no flush for 2 cycles, flush in cycle 3; MCycleOpE=1 alongside PCSrcM=1 → no MCycleStart.
6. RESET asserted in MC_WAIT → next cycle Busy=0, MCycleStart=0; with HAZARD_PERF_EN, StallCount=0 after reset and =4 after 4 Busy cycles.
